// File: rtl/apb_xfer_arbiter.sv
// Round-robin arbiter/sequencer sharing one APB master CSR command port among N_REQ requesters.
// Optional transfer timeout with DRAIN state enabled by defining APB_XFER_ARB_TIMEOUT_EN.
module apb_xfer_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                          pclk_i,
  input  logic                          prst_i,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ-1:0]              write_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   wdata_i,
  output logic [N_REQ-1:0]              ack_o,
  output logic                          err_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic [N_REQ-1:0]              grant_o,
  output logic                          busy_o,
  output logic [ADDR_WIDTH-1:0]         reg_addr_o,
  output logic [DATA_WIDTH-1:0]         reg_wdata_o,
  output logic                          reg_write_o,
  output logic                          reg_enable_o,
  input  logic                          reg_idle_i,
  input  logic [DATA_WIDTH-1:0]         reg_rdata_i
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 1 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_xfer_arbiter: N_REQ must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
`ifdef APB_XFER_ARB_TIMEOUT_EN
    , DRAIN
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        win_q, win_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [N_REQ-1:0]        grant_d, ack_d;
  logic [DATA_WIDTH-1:0]   rdata_d, wdata_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    write_d, enable_d, busy_d;

  logic                    found_hi, found_lo, pick_valid;
  logic [IDX_W-1:0]        idx_hi, idx_lo, pick_idx;
  logic [N_REQ-1:0]        pick_oh;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [DATA_WIDTH-1:0]   pick_wdata;
  logic                    pick_write;

`ifdef APB_XFER_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_q, tmo_d, err_d;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign err_o = 1'b0;
`endif

  // Round-robin pick: first requester above the last winner, else wrap to the lowest.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (req_i[k]) begin
        if (k > 32'(last_q)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            idx_hi   = IDX_W'(k);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          idx_lo   = IDX_W'(k);
        end
      end
    end
    pick_valid = found_hi | found_lo;
    pick_idx   = found_hi ? idx_hi : idx_lo;
  end

  // Winner payload mux.
  always_comb begin
    pick_oh    = '0;
    pick_addr  = '0;
    pick_wdata = '0;
    pick_write = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        pick_oh[k] = 1'b1;
        pick_addr  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        pick_write = write_i[k];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    grant_d = grant_o;
    rdata_d = rdata_o;
    addr_d  = reg_addr_o;
    wdata_d = reg_wdata_o;
    write_d = reg_write_o;
`ifdef APB_XFER_ARB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid && reg_idle_i) begin
          state_d = ISSUE;
          win_d   = pick_idx;
          grant_d = pick_oh;
          addr_d  = pick_addr;
          wdata_d = pick_wdata;
          write_d = pick_write;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
`ifdef APB_XFER_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
        tmo_d     = 1'b0;
`endif
      end
      WAIT_BUSY: begin
`ifdef APB_XFER_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
`endif
        if (!reg_idle_i) begin
          state_d = WAIT_DONE;
        end
`ifdef APB_XFER_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = RESP;
          rdata_d = '0;
          tmo_d   = 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
`ifdef APB_XFER_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
`endif
        if (reg_idle_i) begin
          state_d = RESP;
          rdata_d = reg_rdata_i;
        end
`ifdef APB_XFER_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = RESP;
          rdata_d = '0;
          tmo_d   = 1'b1;
        end
`endif
      end
      RESP: begin
        last_d  = win_q;
        grant_d = '0;
`ifdef APB_XFER_ARB_TIMEOUT_EN
        state_d = tmo_q ? DRAIN : IDLE;
`else
        state_d = IDLE;
`endif
      end
`ifdef APB_XFER_ARB_TIMEOUT_EN
      // Aborted transfer: let the master finish and discard its result.
      DRAIN: begin
        if (reg_idle_i) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // RESP is only entered from the wait states, where grant_o still names the winner.
    ack_d    = (state_d == RESP) ? grant_o : '0;
    enable_d = (state_d == ISSUE);
    busy_d   = (state_d != IDLE);
`ifdef APB_XFER_ARB_TIMEOUT_EN
    err_d    = (state_d == RESP) && tmo_d;
`endif
  end

  // State and registered outputs.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_q      <= IDLE;
      win_q        <= '0;
      last_q       <= IDX_W'(N_REQ - 1);
      ack_o        <= '0;
      rdata_o      <= '0;
      grant_o      <= '0;
      busy_o       <= 1'b0;
      reg_addr_o   <= '0;
      reg_wdata_o  <= '0;
      reg_write_o  <= 1'b0;
      reg_enable_o <= 1'b0;
`ifdef APB_XFER_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      tmo_q        <= 1'b0;
      err_o        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      last_q       <= last_d;
      ack_o        <= ack_d;
      rdata_o      <= rdata_d;
      grant_o      <= grant_d;
      busy_o       <= busy_d;
      reg_addr_o   <= addr_d;
      reg_wdata_o  <= wdata_d;
      reg_write_o  <= write_d;
      reg_enable_o <= enable_d;
`ifdef APB_XFER_ARB_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      tmo_q        <= tmo_d;
      err_o        <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_xfer_arbiter.sv
// Self-checking bench for apb_xfer_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_apb_xfer_arbiter;

  localparam int unsigned N   = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, wr;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic [N-1:0]  ack, grant;
  logic          err, busy, reg_write, reg_enable, reg_idle;
  logic [DW-1:0] rdata, reg_wdata, reg_rdata;
  logic [AW-1:0] reg_addr;

  // APB master model
  logic          m_busy, m_stuck, m_force;
  int            m_cnt, m_wait;
  logic [DW-1:0] m_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_xfer_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk_i(clk), .prst_i(rst),
    .req_i(req), .write_i(wr),
    .addr_i({a1, a0}), .wdata_i({d1, d0}),
    .ack_o(ack), .err_o(err), .rdata_o(rdata),
    .grant_o(grant), .busy_o(busy),
    .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata),
    .reg_write_o(reg_write), .reg_enable_o(reg_enable),
    .reg_idle_i(reg_idle), .reg_rdata_i(reg_rdata)
  );

  // Master: busy from the cycle after enable, idle again with rdata 3+wait cycles later.
  assign reg_idle = !m_busy && !m_force;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy    <= 1'b0;
      m_cnt     <= 0;
      reg_rdata <= '0;
    end else begin
      reg_rdata <= '0;
      if (!m_busy) begin
        if (reg_enable && !m_force) begin
          m_busy <= 1'b1;
          m_cnt  <= 1 + m_wait;
        end
      end else if (m_cnt == 0) begin
        if (!m_stuck) begin
          m_busy    <= 1'b0;
          reg_rdata <= m_data;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // An ack is always a single bit.
  always @(negedge clk) begin
    if (!rst && ack != '0) begin
      checks++;
      if ($countones(ack) != 1) begin
        failures++;
        $display("FAIL ack_onehot: ack=%b required exactly one bit", ack);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, 64'(ack), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata), 64'd0);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_reg_addr"}, 64'(reg_addr), 64'd0);
    chk({tag, "_reg_wdata"}, 64'(reg_wdata), 64'd0);
    chk({tag, "_reg_write"}, 64'(reg_write), 64'd0);
    chk({tag, "_reg_enable"}, 64'(reg_enable), 64'd0);
  endtask

  // Cycle 0 is the cycle in which the caller set the inputs; returns at the ack negedge.
  task automatic wait_ack(output int en_c, output int n_en, output int ack_c, output logic [N-1:0] g);
    en_c  = -1;
    n_en  = 0;
    ack_c = -1;
    g     = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (reg_enable) begin
        n_en++;
        if (en_c < 0) begin
          en_c = c;
          g    = grant;
        end
      end
      if (ack != '0) begin
        ack_c = c;
        break;
      end
    end
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  wr;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            wt;
    logic [DW-1:0] sdata;
    logic [N-1:0]  exp_ack;
    int            exp_lat;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int en_c, n_en, ack_c, bad;
    logic [N-1:0] g;

    vecs[0] = '{req: 2'b01, wr: 2'b00, a0: 32'h40, a1: 32'h0, d0: 32'hAAAA0000, d1: 32'h0,
                wt: 0, sdata: 32'hDEADBEEF, exp_ack: 2'b01, exp_lat: 5,
                exp_wr: 1'b0, exp_addr: 32'h40, exp_wdata: 32'hAAAA0000};
    vecs[1] = '{req: 2'b10, wr: 2'b10, a0: 32'h0, a1: 32'h10, d0: 32'h0, d1: 32'h12345678,
                wt: 3, sdata: 32'h0BADF00D, exp_ack: 2'b10, exp_lat: 8,
                exp_wr: 1'b1, exp_addr: 32'h10, exp_wdata: 32'h12345678};
    vecs[2] = '{req: 2'b01, wr: 2'b00, a0: 32'h44, a1: 32'h0, d0: 32'h0, d1: 32'h0,
                wt: 1, sdata: 32'h11112222, exp_ack: 2'b01, exp_lat: 6,
                exp_wr: 1'b0, exp_addr: 32'h44, exp_wdata: 32'h0};
    vecs[3] = '{req: 2'b10, wr: 2'b00, a0: 32'h0, a1: 32'h80, d0: 32'h0, d1: 32'h55,
                wt: 0, sdata: 32'hCAFEBABE, exp_ack: 2'b10, exp_lat: 5,
                exp_wr: 1'b0, exp_addr: 32'h80, exp_wdata: 32'h55};

    rst = 1'b1; req = '0; wr = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    m_stuck = 1'b0; m_force = 1'b0; m_wait = 0; m_data = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Table-driven single transfers
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req = vecs[i].req; wr = vecs[i].wr;
      a0 = vecs[i].a0; a1 = vecs[i].a1; d0 = vecs[i].d0; d1 = vecs[i].d1;
      m_wait = vecs[i].wt; m_data = vecs[i].sdata;
      wait_ack(en_c, n_en, ack_c, g);
      chk($sformatf("v%0d_enable_cycle", i), 64'(en_c), 64'd1);
      chk($sformatf("v%0d_enable_pulses", i), 64'(n_en), 64'd1);
      chk($sformatf("v%0d_grant", i), 64'(g), 64'(vecs[i].exp_ack));
      chk($sformatf("v%0d_ack_cycle", i), 64'(ack_c), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_ack", i), 64'(ack), 64'(vecs[i].exp_ack));
      chk($sformatf("v%0d_err", i), 64'(err), 64'd0);
      chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(vecs[i].sdata));
      chk($sformatf("v%0d_reg_write", i), 64'(reg_write), 64'(vecs[i].exp_wr));
      chk($sformatf("v%0d_reg_addr", i), 64'(reg_addr), 64'(vecs[i].exp_addr));
      chk($sformatf("v%0d_reg_wdata", i), 64'(reg_wdata), 64'(vecs[i].exp_wdata));
      @(posedge clk); #1;
      req = '0;
      @(negedge clk);
      chk($sformatf("v%0d_idle_grant", i), 64'(grant), 64'd0);
      chk($sformatf("v%0d_idle_busy", i), 64'(busy), 64'd0);
    end

    // Both requesters held for four transfers: grants alternate 0,1,0,1
    @(posedge clk); #1;
    wr = '0; a0 = 32'h100; a1 = 32'h200; m_wait = 0; m_data = 32'h55AA0000;
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_ack(en_c, n_en, ack_c, g);
      chk($sformatf("rr%0d_grant", t), 64'(g), (t % 2 == 0) ? 64'd1 : 64'd2);
      chk($sformatf("rr%0d_ack_cycle", t), 64'(ack_c), 64'd5);
      chk($sformatf("rr%0d_ack", t), 64'(ack), (t % 2 == 0) ? 64'd1 : 64'd2);
      chk($sformatf("rr%0d_reg_addr", t), 64'(reg_addr), (t % 2 == 0) ? 64'h100 : 64'h200);
    end
    @(posedge clk); #1;
    req = '0;

    // Master not idle: no grant until idle returns
    @(posedge clk); #1;
    m_force = 1'b1; a0 = 32'h300; m_data = 32'h13572468; req = 2'b01;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (reg_enable || grant != '0) bad++;
    end
    chk("idle_hold_no_grant", 64'(bad), 64'd0);
    chk("idle_hold_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    m_force = 1'b0;
    wait_ack(en_c, n_en, ack_c, g);
    chk("idle_rel_enable_cycle", 64'(en_c), 64'd1);
    chk("idle_rel_ack_cycle", 64'(ack_c), 64'd5);
    chk("idle_rel_ack", 64'(ack), 64'd1);
    chk("idle_rel_rdata", 64'(rdata), 64'h13572468);
    @(posedge clk); #1;
    req = '0;

    // Reset during WAIT_DONE aborts silently; afterwards requester 0 is top priority again
    @(posedge clk); #1;
    a1 = 32'h400; m_wait = 10; m_data = 32'h99999999; req = 2'b10;
    repeat (5) @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd1);
    rst = 1'b1; req = '0;
    @(posedge clk); #1;
    chk_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack != '0 || reg_enable) bad++;
    end
    chk("rst_mid_no_ack", 64'(bad), 64'd0);
    @(posedge clk); #1;
    m_wait = 0; m_data = 32'h2468ACE0; a0 = 32'h500; req = 2'b11;
    wait_ack(en_c, n_en, ack_c, g);
    chk("post_rst_grant", 64'(g), 64'd1);
    chk("post_rst_ack_cycle", 64'(ack_c), 64'd5);
    chk("post_rst_rdata", 64'(rdata), 64'h2468ACE0);
    @(posedge clk); #1;
    req = '0;

`ifdef APB_XFER_ARB_TIMEOUT_EN
    // Hung slave: abort with err, then hold off new grants until the master goes idle
    @(posedge clk); #1;
    m_stuck = 1'b1; m_data = 32'h77777777; a0 = 32'h600; req = 2'b01;
    wait_ack(en_c, n_en, ack_c, g);
    chk("tmo_ack_cycle", 64'(ack_c), 64'(2 + TMO));
    chk("tmo_ack", 64'(ack), 64'd1);
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;
    req = '0;
    @(posedge clk); #1;
    req = 2'b01;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (reg_enable || grant != '0) bad++;
    end
    chk("drain_no_grant", 64'(bad), 64'd0);
    chk("drain_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    m_stuck = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("drain_late_rdata", 64'(rdata), 64'd0);
    wait_ack(en_c, n_en, ack_c, g);
    chk("drain_next_ack_cycle", 64'(ack_c), 64'd5);
    chk("drain_next_err", 64'(err), 64'd0);
    chk("drain_next_rdata", 64'(rdata), 64'h77777777);
    @(posedge clk); #1;
    req = '0;
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
